// File: rtl/key_pkg.sv
// Shared constants, types and helpers for the key event debouncer.
package key_pkg;

  localparam int unsigned N_KEYS_DEF       = 8;
  localparam int unsigned DEBOUNCE_CYC_DEF = 20000;
  localparam int unsigned CNT_W_DEF        = 15;
  localparam int unsigned REPEAT_DELAY_DEF = 500000;
  localparam int unsigned REPEAT_RATE_DEF  = 100000;
  localparam int unsigned KEY_IDX_W        = 4;

  typedef logic [KEY_IDX_W-1:0] key_idx_t;

  typedef enum logic [1:0] {
    REP_IDLE,
    REP_DELAY,
    REP_RATE
  } rep_state_e;

  // Returns {found, index of lowest set bit}.
  function automatic logic [KEY_IDX_W:0] lowest_set(input logic [15:0] v);
    logic [KEY_IDX_W:0] res;
    res = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (v[i] && !res[KEY_IDX_W]) res = {1'b1, key_idx_t'(i)};
    end
    return res;
  endfunction

endpackage

// File: rtl/key_event_debounce_if.sv
// Key vector in, debounced key events out; master drives raw keys, slave is the debouncer.
interface key_event_debounce_if #(
  parameter int unsigned N_KEYS = key_pkg::N_KEYS_DEF
);
  import key_pkg::*;

  logic [N_KEYS-1:0] button_raw;
  logic              clr_toggle;
  logic [N_KEYS-1:0] key_stable;
  logic [N_KEYS-1:0] key_press;
  logic [N_KEYS-1:0] key_release;
  logic [N_KEYS-1:0] key_toggle;
  key_idx_t          key_code;
  logic              key_valid;

  modport master (
    output button_raw, clr_toggle,
    input  key_stable, key_press, key_release, key_toggle, key_code, key_valid
  );

  modport slave (
    input  button_raw, clr_toggle,
    output key_stable, key_press, key_release, key_toggle, key_code, key_valid
  );

endinterface

// File: rtl/key_debounce_cell.sv
// One key: input register, mismatch counter, debounced level and rise/fall pulses.
module key_debounce_cell #(
  parameter int unsigned DEBOUNCE_CYC = key_pkg::DEBOUNCE_CYC_DEF,
  parameter int unsigned CNT_W        = key_pkg::CNT_W_DEF
) (
  input  logic clk_1mhz,
  input  logic rst_n,
  input  logic raw,
  output logic stable,
  output logic rise,
  output logic fall,
  output logic rise_nxt
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             b_q, b_d;
  logic             stable_q, stable_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter clears on any match, so it never runs past CNT_LAST.
  always_comb begin
    b_d      = raw;
    cnt_d    = '0;
    stable_d = stable_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    if (b_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = b_q;
        rise_d   = b_q;
        fall_d   = ~b_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_1mhz or negedge rst_n) begin
    if (!rst_n) begin
      b_q      <= 1'b0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign stable   = stable_q;
  assign rise     = rise_q;
  assign fall     = fall_q;
  assign rise_nxt = rise_d;

endmodule

// File: rtl/key_event_debounce.sv
// Debounced key levels, press/release pulses, toggle latches and last-press code.
// Optional auto-repeat of the lowest held key when AUTOREPEAT_EN is defined.
module key_event_debounce
  import key_pkg::*;
#(
  parameter int unsigned N_KEYS       = N_KEYS_DEF,
  parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
  parameter int unsigned CNT_W        = CNT_W_DEF,
  parameter int unsigned REPEAT_DELAY = REPEAT_DELAY_DEF,
  parameter int unsigned REPEAT_RATE  = REPEAT_RATE_DEF
) (
  input  logic               clk_1mhz,
  input  logic               rst_n,
  key_event_debounce_if.slave bus
);

  logic [N_KEYS-1:0] stable_w, rise_w, fall_w, rise_nxt_w, rep_nxt;
  logic [N_KEYS-1:0] press_q, press_d;
  logic [N_KEYS-1:0] toggle_q, toggle_d;
  key_idx_t          code_q, code_d;
  logic              valid_q, valid_d;
  logic [KEY_IDX_W:0] press_lo;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_cell
    key_debounce_cell #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .CNT_W       (CNT_W)
    ) u_cell (
      .clk_1mhz(clk_1mhz),
      .rst_n   (rst_n),
      .raw     (bus.button_raw[g]),
      .stable  (stable_w[g]),
      .rise    (rise_w[g]),
      .fall    (fall_w[g]),
      .rise_nxt(rise_nxt_w[g])
    );
  end

`ifdef AUTOREPEAT_EN
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RCNT_W  = $clog2(REP_MAX + 1);

  rep_state_e         rep_st_q, rep_st_d;
  key_idx_t           trk_q, trk_d;
  logic [RCNT_W-1:0]  rcnt_q, rcnt_d;
  logic               rep_fire;
  logic [KEY_IDX_W:0] stable_lo;

  // Tracks the lowest stable key; rcnt counts cycles since it became lowest.
  always_comb begin
    rep_st_d  = rep_st_q;
    trk_d     = trk_q;
    rcnt_d    = rcnt_q + 1'b1;
    rep_fire  = 1'b0;
    stable_lo = lowest_set(16'(stable_w));
    if (!stable_lo[KEY_IDX_W]) begin
      rep_st_d = REP_IDLE;
      rcnt_d   = '0;
    end else if (rep_st_q == REP_IDLE || stable_lo[KEY_IDX_W-1:0] != trk_q) begin
      rep_st_d = REP_DELAY;
      trk_d    = stable_lo[KEY_IDX_W-1:0];
      rcnt_d   = RCNT_W'(1);
    end else if ((rep_st_q == REP_DELAY && rcnt_q == RCNT_W'(REPEAT_DELAY - 1)) ||
                 (rep_st_q == REP_RATE  && rcnt_q == RCNT_W'(REPEAT_RATE - 1))) begin
      rep_fire = 1'b1;
      rep_st_d = REP_RATE;
      rcnt_d   = '0;
    end
  end

  always_ff @(posedge clk_1mhz or negedge rst_n) begin
    if (!rst_n) begin
      rep_st_q <= REP_IDLE;
      trk_q    <= '0;
      rcnt_q   <= '0;
    end else begin
      rep_st_q <= rep_st_d;
      trk_q    <= trk_d;
      rcnt_q   <= rcnt_d;
    end
  end

  assign rep_nxt = rep_fire ? (N_KEYS'(1) << trk_q) : '0;
`else
  assign rep_nxt = '0;
`endif

  // Toggles follow the registered genuine rise, so a clear in the press cycle wins.
  always_comb begin
    press_d  = rise_nxt_w | rep_nxt;
    press_lo = lowest_set(16'(press_d));
    valid_d  = press_lo[KEY_IDX_W];
    code_d   = valid_d ? press_lo[KEY_IDX_W-1:0] : code_q;
    toggle_d = bus.clr_toggle ? '0 : (toggle_q ^ rise_w);
  end

  always_ff @(posedge clk_1mhz or negedge rst_n) begin
    if (!rst_n) begin
      press_q  <= '0;
      toggle_q <= '0;
      code_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      press_q  <= press_d;
      toggle_q <= toggle_d;
      code_q   <= code_d;
      valid_q  <= valid_d;
    end
  end

  assign bus.key_stable  = stable_w;
  assign bus.key_press   = press_q;
  assign bus.key_release = fall_w;
  assign bus.key_toggle  = toggle_q;
  assign bus.key_code    = code_q;
  assign bus.key_valid   = valid_q;

endmodule

// File: tb/tb_key_event_debounce.sv
// Randomised scoreboard bench for key_event_debounce (also covers AUTOREPEAT_EN builds).
module tb_key_event_debounce;

  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RR = 5;

  logic clk;
  logic rst_n;

  key_event_debounce_if #(.N_KEYS(8)) bus ();

  key_event_debounce #(
    .N_KEYS      (8),
    .DEBOUNCE_CYC(D),
    .CNT_W       (3),
    .REPEAT_DELAY(RD),
    .REPEAT_RATE (RR)
  ) dut (
    .clk_1mhz(clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] press;
    logic [7:0] rel;
    logic [3:0] code;
  } ev_t;

  ev_t evq[$];
  int  nchecks = 0;
  int  nerrs   = 0;
  int  cyc     = 0;

  // Reference state: sampled-input history and derived outputs.
  logic [7:0] hist[D];
  logic [7:0] m_stab, m_tog, m_gen_prev;
  logic [3:0] m_code;
  int         lo_prev, lo_start;

  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrs++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // A key's level is accepted once its last D samples all differ from the current level.
  always @(posedge clk) begin : model
    logic [7:0] acc, nstab, gen, rel, prs;
    bool_blk: begin end
    cyc++;
    if (!rst_n) begin
      for (int j = 0; j < D; j++) hist[j] = '0;
      m_stab = '0; m_tog = '0; m_gen_prev = '0; m_code = '0;
      lo_prev = -1; lo_start = 0;
    end else begin
      for (int k = 0; k < 8; k++) begin
        acc[k] = 1'b1;
        for (int j = 0; j < D; j++) if (hist[j][k] == m_stab[k]) acc[k] = 1'b0;
      end
      nstab = m_stab ^ acc;
      gen   = acc & nstab;
      rel   = acc & ~nstab;
      prs   = gen;
`ifdef AUTOREPEAT_EN
      if (lo_prev >= 0) begin
        int age;
        age = cyc - lo_start;
        if (age >= RD && ((age - RD) % RR) == 0) prs[lo_prev] = 1'b1;
      end
`endif
      m_tog      = bus.clr_toggle ? 8'h00 : (m_tog ^ m_gen_prev);
      m_gen_prev = gen;
      if (prs != 0) m_code = 4'(lowest(prs));
      m_stab = nstab;
      if (lowest(m_stab) != lo_prev) begin
        lo_prev  = lowest(m_stab);
        lo_start = cyc;
      end
      for (int j = D - 1; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = bus.button_raw;
      if (prs != 0 || rel != 0) evq.push_back('{cyc, prs, rel, m_code});
    end
  end

  always @(posedge clk) begin : monitor
    logic presented;
    ev_t  e;
    #1;
    chk("key_stable", 32'(bus.key_stable), 32'(m_stab));
    chk("key_toggle", 32'(bus.key_toggle), 32'(m_tog));
    chk("key_code",   32'(bus.key_code),   32'(m_code));
    presented = (bus.key_press != 0) || (bus.key_release != 0) || bus.key_valid;
    if (presented) begin
      if (evq.size() == 0) begin
        chk("unexpected_event", {bus.key_press, bus.key_release, 15'd0, bus.key_valid}, 32'd0);
      end else begin
        e = evq.pop_front();
        chk("event_cycle", 32'(cyc), 32'(e.cyc));
        chk("key_press",   32'(bus.key_press),   32'(e.press));
        chk("key_release", 32'(bus.key_release), 32'(e.rel));
        chk("key_valid",   32'(bus.key_valid),   32'(e.press != 0));
      end
    end else if (evq.size() != 0 && evq[0].cyc <= cyc) begin
      e = evq.pop_front();
      chk("missing_event", 32'(0), {e.press, e.rel, 16'd1});
    end
  end

  task automatic step(input logic [7:0] v, input logic c, input int n);
    repeat (n) begin
      @(negedge clk);
      bus.button_raw = v;
      bus.clr_toggle = c;
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.button_raw = '0;
    bus.clr_toggle = 1'b0;
    step(8'h00, 1'b0, 3);
    @(negedge clk) rst_n = 1'b1;
    // hold, glitch, double press of key 5, simultaneous press with clear
    step(8'h04, 1'b0, 8);  step(8'h00, 1'b0, 8);
    step(8'h01, 1'b0, 3);  step(8'h00, 1'b0, 8);
    repeat (2) begin step(8'h20, 1'b0, 8); step(8'h00, 1'b0, 8); end
    step(8'h12, 1'b0, 5);  step(8'h12, 1'b1, 1); step(8'h12, 1'b0, 6); step(8'h00, 1'b0, 8);
    // reset mid-count with key 0 held across release
    step(8'h01, 1'b0, 3);
    @(negedge clk) rst_n = 1'b0;
    step(8'h01, 1'b0, 2);
    @(negedge clk) rst_n = 1'b1;
    step(8'h01, 1'b0, 10); step(8'h00, 1'b0, 8);
    // long hold of key 3 exercises auto-repeat when enabled
    step(8'h08, 1'b0, 30); step(8'h00, 1'b0, 8);
    repeat (300) begin
      step(8'($urandom & $urandom), ($urandom_range(0, 15) == 0), $urandom_range(1, 25));
    end
    step(8'h00, 1'b0, D + 6);
    @(posedge clk); #2;
    chk("events_left", 32'(evq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
    $finish;
  end

endmodule
